// File: rtl/ldst_dmem_slave.sv
// Load/store responder: word SRAM behind the LSU with a 2-deep in-order response buffer.
// Latency: response visible the cycle after accept. Backpressure: req_rdy drops once two responses are outstanding.

// Generic response FIFO (power-of-2 depth).
// Latency: pushed entry visible at head the cycle after push.
// Backpressure: none internally; the caller must never push when full or pop when empty.
module ldst_rsp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_vld,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop_vld,
  output logic [W-1:0]               head_dat,
  output logic [$clog2(DEPTH+1)-1:0] cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  ram [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + 1'b1;
      if (pop_vld)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(push_vld) - CW'(pop_vld);
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld) ram[wr_ptr] <= push_dat;
  end

  assign head_dat = ram[rd_ptr];
endmodule

// Data-memory responder: decodes, performs the SRAM access, queues the response.
// Latency: 1 cycle accept-to-rsp_vld with an empty buffer; one response per cycle when streaming.
// Backpressure: at most 2 outstanding responses (buffered + in-flight read); req_rdy low beyond that.
module ldst_dmem_slave #(
  parameter int            AW        = 32,
  parameter int            DW        = 32,
  parameter int            DEPTH     = 1024,
  parameter logic [AW-1:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_vld,
  output logic            req_rdy,
  input  logic [AW-1:0]   req_addr,
  input  logic            req_st,
  input  logic [DW-1:0]   req_data,
  input  logic [DW/8-1:0] req_strobe,
  output logic            rsp_vld,
  input  logic            rsp_rdy,
  output logic [DW-1:0]   rsp_data,
  output logic            rsp_ok
);
  localparam int            NB    = DW / 8;
  localparam int            LB    = $clog2(NB);
  localparam int            IW    = $clog2(DEPTH);
  localparam logic [AW:0]   SPAN  = (AW+1)'(DEPTH * NB);
  localparam logic [AW-1:0] LMASK = AW'(NB - 1);

  typedef struct packed {
    logic          ok;
    logic [DW-1:0] dat;
  } rsp_t;

  logic [AW-1:0] off;
  logic          err;
  logic [IW-1:0] idx;
  logic          accept;
  logic          pop;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_q;

  logic          stage_vld;
  logic          stage_ok;
  logic          stage_ld;
  rsp_t          stage_ent;

  logic          buf_push;
  logic          buf_pop;
  rsp_t          buf_head;
  logic [1:0]    buf_cnt;
  rsp_t          head;
  logic [2:0]    occ_after_pop;

  assign off    = req_addr - BASE_ADDR;
  assign err    = ({1'b0, off} >= SPAN) || ((off & LMASK) != '0);
  assign idx    = off[LB +: IW];
  assign accept = req_vld && req_rdy;

  // Errored requests never touch the array, neither for write nor for read.
  always_ff @(posedge clk) begin
    if (accept && !err) begin
      if (req_st) begin
        for (int i = 0; i < NB; i++) begin
          if (req_strobe[i]) mem[idx][8*i +: 8] <= req_data[8*i +: 8];
        end
      end else begin
        rd_q <= mem[idx];
      end
    end
  end

  // Stage holds the request accepted last edge while its SRAM read completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_vld <= 1'b0;
      stage_ok  <= 1'b0;
      stage_ld  <= 1'b0;
    end else begin
      stage_vld <= accept;
      stage_ok  <= !err;
      stage_ld  <= !req_st && !err;
    end
  end

  assign stage_ent.ok  = stage_ok;
  assign stage_ent.dat = stage_ld ? rd_q : '0;

  // The stage drains every cycle: straight out when the buffer is empty and popped, else into the buffer.
  assign pop      = rsp_vld && rsp_rdy;
  assign buf_pop  = pop && (buf_cnt != 2'd0);
  assign buf_push = stage_vld && !((buf_cnt == 2'd0) && pop);

  ldst_rsp_fifo #(
    .W     ($bits(rsp_t)),
    .DEPTH (2)
  ) u_rsp_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (buf_push),
    .push_dat (stage_ent),
    .pop_vld  (buf_pop),
    .head_dat (buf_head),
    .cnt      (buf_cnt)
  );

  assign head     = (buf_cnt != 2'd0) ? buf_head : stage_ent;
  assign rsp_vld  = (buf_cnt != 2'd0) || stage_vld;
  assign rsp_data = rsp_vld ? head.dat : '0;
  assign rsp_ok   = rsp_vld && head.ok;

  assign occ_after_pop = {1'b0, buf_cnt} + {2'b00, stage_vld} - {2'b00, pop};
  assign req_rdy       = !rst && (occ_after_pop < 3'd2);
endmodule

// File: tb/tb_ldst_dmem_slave.sv
// Randomized bench for ldst_dmem_slave against a word-array + expected-response-queue model.
module tb_ldst_dmem_slave;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        req_vld;
  logic        req_rdy;
  logic [31:0] req_addr;
  logic        req_st;
  logic [31:0] req_data;
  logic [3:0]  req_strobe;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [31:0] rsp_data;
  logic        rsp_ok;

  int checks;
  int errors;
  int acc_cnt;
  int rdy_mode;

  logic [31:0] mmem [DEPTH];
  logic [32:0] exp_q [$];

  ldst_dmem_slave #(
    .AW(32), .DW(32), .DEPTH(DEPTH), .BASE_ADDR(BASE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_vld    (req_vld),
    .req_rdy    (req_rdy),
    .req_addr   (req_addr),
    .req_st     (req_st),
    .req_data   (req_data),
    .req_strobe (req_strobe),
    .rsp_vld    (rsp_vld),
    .rsp_rdy    (rsp_rdy),
    .rsp_data   (rsp_data),
    .rsp_ok     (rsp_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference behaviour: one access against a plain word array, result as {ok, data}.
  function automatic logic [32:0] model_access(input logic st, input logic [31:0] a,
                                               input logic [31:0] d, input logic [3:0] s);
    logic [31:0] o;
    int          w;
    o = a - BASE;
    if (o >= DEPTH * 4 || o % 4 != 0) return {1'b0, 32'h0};
    w = int'(o / 4);
    if (!st) return {1'b1, mmem[w]};
    for (int b = 0; b < 4; b++)
      if (s[b]) mmem[w][8*b +: 8] = d[8*b +: 8];
    return {1'b1, 32'h0};
  endfunction

  always begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       rsp_rdy = 1'b0;
      1:       rsp_rdy = 1'b1;
      default: rsp_rdy = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: compare outputs with the head of the expected queue, then advance the model.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      check("rst_rsp_vld", rsp_vld, 0);
    end else begin
      logic exp_pop;
      exp_pop = (exp_q.size() != 0) && rsp_rdy;
      check("no_push_full", (dut.buf_push && dut.buf_cnt == 2'd2), 0);
      check("rsp_vld", rsp_vld, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("rsp_ok", rsp_ok, exp_q[0][32]);
        check("rsp_data", rsp_data, exp_q[0][31:0]);
      end
      check("req_rdy", req_rdy, (exp_q.size() - int'(exp_pop)) < 2);
      if (exp_pop) void'(exp_q.pop_front());
      if (req_vld && req_rdy) begin
        exp_q.push_back(model_access(req_st, req_addr, req_data, req_strobe));
        acc_cnt++;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic st, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit done;
    req_vld = 1'b1; req_st = st; req_addr = a; req_data = d; req_strobe = s;
    done = 1'b0;
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge clk);
      done = req_rdy && !rst;
      @(posedge clk);
      #1;
    end
    req_vld = 1'b0;
    if (!done) check("req_timeout", 0, 1);
  endtask

  task automatic expect_rsp(input string tag, input logic ok, input logic [31:0] d);
    @(negedge clk);
    check({tag, "_vld"}, rsp_vld, 1);
    check({tag, "_ok"}, rsp_ok, ok);
    check({tag, "_data"}, rsp_data, d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] saved;
    int          base_acc;
    checks = 0; errors = 0; acc_cnt = 0; rdy_mode = 0;
    rsp_rdy = 1'b0;
    rst = 1'b1; req_vld = 1'b0; req_st = 1'b0; req_addr = '0; req_data = '0; req_strobe = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("t1_rdy_after_rst", req_rdy, 1);
    @(posedge clk);
    #1;
    rdy_mode = 1;
    idle(2);

    for (int i = 0; i < DEPTH; i++) send(1'b1, BASE + 32'(4 * i), $urandom, 4'hF);
    idle(3);

    send(1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
    expect_rsp("t2_st", 1'b1, 32'h0);
    send(1'b0, BASE + 32'h10, 32'h0, 4'h0);
    expect_rsp("t2_ld", 1'b1, 32'hDEAD_BEEF);

    send(1'b1, BASE + 32'h20, 32'h1122_3344, 4'hF);
    expect_rsp("t3_pre", 1'b1, 32'h0);
    send(1'b1, BASE + 32'h20, 32'hAABB_CCDD, 4'b0101);
    expect_rsp("t3_st", 1'b1, 32'h0);
    send(1'b0, BASE + 32'h20, 32'h0, 4'h0);
    expect_rsp("t3_ld", 1'b1, 32'h11BB_33DD);
    send(1'b1, BASE + 32'h20, 32'hFFFF_FFFF, 4'h0);
    expect_rsp("t3_st_nostrb", 1'b1, 32'h0);

    send(1'b0, BASE + 32'h2, 32'h0, 4'h0);
    expect_rsp("t4_misalign", 1'b0, 32'h0);
    send(1'b0, BASE + 32'(4 * DEPTH), 32'h0, 4'h0);
    expect_rsp("t4_oor_hi", 1'b0, 32'h0);
    send(1'b0, BASE - 32'h4, 32'h0, 4'h0);
    expect_rsp("t4_oor_lo", 1'b0, 32'h0);
    send(1'b1, BASE + 32'(4 * DEPTH), 32'h0BAD_0BAD, 4'hF);
    expect_rsp("t4_st_oor", 1'b0, 32'h0);

    rdy_mode = 0;
    idle(2);
    base_acc = acc_cnt;
    saved = '0;
    fork
      begin
        send(1'b0, BASE + 32'h10, 32'h0, 4'h0);
        send(1'b0, BASE + 32'h20, 32'h0, 4'h0);
        send(1'b0, BASE + 32'h30, 32'h0, 4'h0);
        send(1'b0, BASE + 32'h40, 32'h0, 4'h0);
      end
      begin
        repeat (3) @(negedge clk);
        saved = rsp_data;
        repeat (3) @(negedge clk);
        check("t5_accepted", acc_cnt - base_acc, 2);
        check("t5_req_rdy", req_rdy, 0);
        check("t5_stable", rsp_data, saved);
        check("t5_vld", rsp_vld, 1);
        @(posedge clk);
        #1 rdy_mode = 1;
      end
    join
    idle(6);

    rsp_rdy = rsp_rdy;
    rdy_mode = 0;
    idle(2);
    send(1'b0, BASE + 32'h10, 32'h0, 4'h0);
    #1 rst = 1'b1;
    #1;
    check("t1_async_vld", rsp_vld, 0);
    check("t1_async_data", rsp_data, 0);
    check("t1_async_ok", rsp_ok, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("t1_rdy_after_midrst", req_rdy, 1);
    @(posedge clk);
    #1;

    send(1'b1, BASE + 32'h80, 32'h5A5A_1234, 4'hF);
    send(1'b0, BASE + 32'h10, 32'h0, 4'h0);
    #1 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    rdy_mode = 1;
    repeat (3) begin
      @(negedge clk);
      check("t6_quiet", rsp_vld, 0);
    end
    @(posedge clk);
    #1;
    send(1'b0, BASE + 32'h80, 32'h0, 4'h0);
    expect_rsp("t6_st_kept", 1'b1, 32'h5A5A_1234);

    rdy_mode = 2;
    for (int i = 0; i < 400; i++) begin
      int          r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      if (r < 7)       a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      else if (r == 7) a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
      else if (r == 8) a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 15));
      else             a = $urandom;
      send(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
      idle($urandom_range(0, 2));
    end

    rdy_mode = 1;
    for (int i = 0; i < DEPTH; i++) send(1'b0, BASE + 32'(4 * i), 32'h0, 4'h0);
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
